// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32 main decoder and control pipeline.
// ctrl_t is the per-instruction control bundle carried from EX to WB.
package ctrl_pkg;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic [1:0] mux_final;
    logic       lui;
    logic       auipc;
    logic       muldiv;
  } ctrl_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Wide enough for MULDIV_LAT-1 with MULDIV_LAT up to 16.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder: opcode/funct7 to control bundle, plus flags
// telling the hazard logic which source registers the instruction reads.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2
);

  always_comb begin
    ctrl    = '0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
        ctrl.muldiv    = MULDIV_EN && (funct7 == F7_MULDIV);
        use_rs2        = 1'b1;
      end
      OP_ITYPE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mux_final  = 2'b01;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_op    = 2'b01;
        ctrl.branch    = 1'b1;
        ctrl.mux_final = 2'b10;
        use_rs2        = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = 2'b11;
        ctrl.branch    = 1'b1;
        ctrl.mux_final = 2'b10;
        use_rs1        = 1'b0;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.mux_final = 2'b11;
      end
      OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.lui       = 1'b1;
        use_rs1        = 1'b0;
      end
      OP_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.auipc     = 1'b1;
        use_rs1        = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control registers with load-use, multi-cycle muldiv and flush
// handling for the 5-stage RV32 core.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter bit MULDIV_EN  = 1'b1,
  parameter int MULDIV_LAT = 4,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              flush,
  output logic              stall_id,
  output logic              muldiv_busy,
  output ctrl_t             ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output ctrl_t             mem_ctrl,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_valid,
  output ctrl_t             wb_ctrl,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_valid
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  ctrl_t              dec_ctrl;
  logic               use_rs1, use_rs2;
  logic [REG_AW-1:0]  id_rd, id_rs1, id_rs2;
  logic               load_use, accept;
  logic               unused_funct3;

  ctrl_t              ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [REG_AW-1:0]  ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic               ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  ctrl_decode #(.MULDIV_EN(MULDIV_EN)) u_decode (
    .opcode  (id_instr[6:0]),
    .funct7  (id_instr[31:25]),
    .ctrl    (dec_ctrl),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign id_rd         = id_instr[7 +: REG_AW];
  assign id_rs1        = id_instr[15 +: REG_AW];
  assign id_rs2        = id_instr[20 +: REG_AW];
  assign unused_funct3 = ^id_instr[14:12];

  assign load_use = id_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                    ((use_rs1 && (id_rs1 == ex_rd_q)) || (use_rs2 && (id_rs2 == ex_rd_q)));
  assign muldiv_busy = ex_valid_q && ex_ctrl_q.muldiv && (cnt_q != '0);
  // A flush redirects fetch, so holding the PC would only delay the redirect.
  assign stall_id = !flush && (load_use || muldiv_busy);
  assign accept   = id_valid && !flush && !load_use;

  always_comb begin
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    ex_valid_d  = ex_valid_q;
    cnt_d       = cnt_q;
    mem_ctrl_d  = ex_ctrl_q;
    mem_rd_d    = ex_rd_q;
    mem_valid_d = ex_valid_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_rd_d     = mem_rd_q;
    wb_valid_d  = mem_valid_q;
    if (muldiv_busy) begin
      cnt_d       = cnt_q - 1'b1;
      mem_ctrl_d  = '0;
      mem_rd_d    = '0;
      mem_valid_d = 1'b0;
    end else if (accept) begin
      ex_ctrl_d  = dec_ctrl;
      ex_rd_d    = id_rd;
      ex_valid_d = 1'b1;
      cnt_d      = dec_ctrl.muldiv ? CNT_LOAD : '0;
    end else begin
      ex_ctrl_d  = '0;
      ex_rd_d    = '0;
      ex_valid_d = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      cnt_q       <= '0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      mem_valid_q <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      ex_valid_q  <= ex_valid_d;
      cnt_q       <= cnt_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      mem_valid_q <= mem_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign ex_ctrl   = ex_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign ex_valid  = ex_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_rd    = mem_rd_q;
  assign mem_valid = mem_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_rd     = wb_rd_q;
  assign wb_valid  = wb_valid_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: one instance with muldiv enabled (latency 4)
// and one with muldiv disabled, driven by the same ID-stage stimulus.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  localparam logic [12:0] B_R     = 13'b0_0_1_0_0_10_0_00_0_0_0;
  localparam logic [12:0] B_MUL   = 13'b0_0_1_0_0_10_0_00_0_0_1;
  localparam logic [12:0] B_LOAD  = 13'b1_1_1_1_0_00_0_01_0_0_0;
  localparam logic [12:0] B_LUI   = 13'b1_0_1_0_0_00_0_00_1_0_0;
  localparam logic [12:0] B_AUIPC = 13'b1_0_1_0_0_00_0_00_0_1_0;
  localparam logic [12:0] B_JALR  = 13'b0_0_1_0_0_00_1_11_0_0_0;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, flush;
  logic [31:0] id_instr;

  logic        stall_id, muldiv_busy, ex_valid, mem_valid, wb_valid;
  ctrl_t       ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;

  logic        stall_id0, muldiv_busy0, ex_valid0, mem_valid0, wb_valid0;
  ctrl_t       ex_ctrl0, mem_ctrl0, wb_ctrl0;
  logic [4:0]  ex_rd0, mem_rd0, wb_rd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.MULDIV_EN(1'b1), .MULDIV_LAT(4), .REG_AW(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .stall_id(stall_id), .muldiv_busy(muldiv_busy),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .mem_ctrl(mem_ctrl), .mem_rd(mem_rd), .mem_valid(mem_valid),
    .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .wb_valid(wb_valid)
  );

  ctrl_pipeline #(.MULDIV_EN(1'b0), .MULDIV_LAT(4), .REG_AW(5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .stall_id(stall_id0), .muldiv_busy(muldiv_busy0),
    .ex_ctrl(ex_ctrl0), .ex_rd(ex_rd0), .ex_valid(ex_valid0),
    .mem_ctrl(mem_ctrl0), .mem_rd(mem_rd0), .mem_valid(mem_valid0),
    .wb_ctrl(wb_ctrl0), .wb_rd(wb_rd0), .wb_valid(wb_valid0)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OP_RTYPE};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {12'd0, rs1, 3'b010, rd, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    id_valid = 1'b0;
    flush    = 1'b0;
    id_instr = 32'h0;
    tick();
    tick();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_stall", 32'(stall_id), 32'd0);
    check("rst_busy", 32'(muldiv_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2 through the pipe
    id_valid = 1'b1;
    id_instr = enc_r(7'b0000000, 5'd2, 5'd1, 5'd3);
    tick();
    check("add_ex_ctrl", 32'(ex_ctrl), 32'(B_R));
    check("add_ex_rd", 32'(ex_rd), 32'd3);
    check("add_ex_valid", 32'(ex_valid), 32'd1);
    id_valid = 1'b0;
    tick();
    check("add_mem_rd", 32'(mem_rd), 32'd3);
    tick();
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_rd", 32'(wb_rd), 32'd3);
    check("add_wb_ctrl", 32'(wb_ctrl), 32'(B_R));

    // load-use: lw x5,0(x1) ; add x6,x5,x2
    id_valid = 1'b1;
    id_instr = enc_i(OP_LOAD, 5'd1, 5'd5);
    tick();
    check("lw_ex_ctrl", 32'(ex_ctrl), 32'(B_LOAD));
    id_instr = enc_r(7'b0000000, 5'd2, 5'd5, 5'd6);
    #1;
    check("lu_stall", 32'(stall_id), 32'd1);
    tick();
    check("lu_ex_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_ex_bubble_rd", 32'(ex_rd), 32'd0);
    check("lu_mem_rd", 32'(mem_rd), 32'd5);
    check("lu_stall_released", 32'(stall_id), 32'd0);
    tick();
    check("lu_add_ex_rd", 32'(ex_rd), 32'd6);
    check("lu_add_ex_valid", 32'(ex_valid), 32'd1);

    // load to x0 never stalls
    id_instr = enc_i(OP_LOAD, 5'd1, 5'd0);
    tick();
    id_instr = enc_r(7'b0000000, 5'd2, 5'd0, 5'd6);
    #1;
    check("lu_x0_stall", 32'(stall_id), 32'd0);
    tick();
    check("lu_x0_ex_rd", 32'(ex_rd), 32'd6);
    id_valid = 1'b0;
    tick();
    tick();
    tick();

    // mul x7,x1,x2 followed by add x8,x1,x2
    id_valid = 1'b1;
    id_instr = enc_r(F7_MULDIV, 5'd2, 5'd1, 5'd7);
    tick();
    check("mul_ex_ctrl", 32'(ex_ctrl), 32'(B_MUL));
    check("mul_ex_rd", 32'(ex_rd), 32'd7);
    check("nomd_ex_ctrl", 32'(ex_ctrl0), 32'(B_R));
    id_instr = enc_r(7'b0000000, 5'd2, 5'd1, 5'd8);
    #1;
    check("mul_busy_c0", 32'(muldiv_busy), 32'd1);
    check("mul_stall_c0", 32'(stall_id), 32'd1);
    check("nomd_busy", 32'(muldiv_busy0), 32'd0);
    check("nomd_stall", 32'(stall_id0), 32'd0);
    tick();
    check("mul_busy_c1", 32'(muldiv_busy), 32'd1);
    check("mul_mem_bub_c1", 32'(mem_valid), 32'd0);
    check("mul_ex_hold_c1", 32'(ex_rd), 32'd7);
    check("nomd_ex_adv", 32'(ex_rd0), 32'd8);
    tick();
    check("mul_busy_c2", 32'(muldiv_busy), 32'd1);
    check("mul_mem_bub_c2", 32'(mem_valid), 32'd0);
    tick();
    check("mul_busy_c3", 32'(muldiv_busy), 32'd0);
    check("mul_stall_c3", 32'(stall_id), 32'd0);
    check("mul_mem_bub_c3", 32'(mem_valid), 32'd0);
    check("mul_ex_hold_c3", 32'(ex_rd), 32'd7);
    tick();
    check("mul_mem_rd", 32'(mem_rd), 32'd7);
    check("mul_mem_valid", 32'(mem_valid), 32'd1);
    check("mul_mem_ctrl", 32'(mem_ctrl), 32'(B_MUL));
    check("mul_next_ex_rd", 32'(ex_rd), 32'd8);
    id_valid = 1'b0;
    tick();
    tick();
    tick();

    // flush coincident with load-use
    id_valid = 1'b1;
    id_instr = enc_i(OP_LOAD, 5'd1, 5'd5);
    tick();
    id_instr = enc_r(7'b0000000, 5'd2, 5'd5, 5'd6);
    flush    = 1'b1;
    #1;
    check("fl_stall", 32'(stall_id), 32'd0);
    tick();
    check("fl_ex_valid", 32'(ex_valid), 32'd0);
    check("fl_ex_rd", 32'(ex_rd), 32'd0);
    check("fl_mem_rd", 32'(mem_rd), 32'd5);
    flush    = 1'b0;
    id_valid = 1'b0;
    tick();
    check("fl_wb_load_rd", 32'(wb_rd), 32'd5);
    tick();
    check("fl_wb_valid_a", 32'(wb_valid), 32'd0);
    check("fl_wb_rd_a", 32'(wb_rd), 32'd0);
    tick();
    check("fl_wb_valid_b", 32'(wb_valid), 32'd0);

    // opcode bundles
    id_valid = 1'b1;
    id_instr = enc_i(OP_LUI, 5'd0, 5'd9);
    tick();
    check("lui_ctrl", 32'(ex_ctrl), 32'(B_LUI));
    check("lui_rd", 32'(ex_rd), 32'd9);
    id_instr = enc_i(OP_AUIPC, 5'd0, 5'd10);
    tick();
    check("auipc_ctrl", 32'(ex_ctrl), 32'(B_AUIPC));
    id_instr = enc_i(OP_JALR, 5'd2, 5'd1);
    tick();
    check("jalr_ctrl", 32'(ex_ctrl), 32'(B_JALR));
    id_instr = enc_i(7'b1111111, 5'd0, 5'd11);
    tick();
    check("unk_ctrl", 32'(ex_ctrl), 32'd0);
    check("unk_valid", 32'(ex_valid), 32'd1);
    check("unk_rd", 32'(ex_rd), 32'd11);
    id_valid = 1'b0;
    tick();
    tick();
    tick();

    // asynchronous reset while a muldiv occupies EX
    id_valid = 1'b1;
    id_instr = enc_r(F7_MULDIV, 5'd2, 5'd1, 5'd7);
    tick();
    id_valid = 1'b0;
    tick();
    check("ar_busy_before", 32'(muldiv_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(muldiv_busy), 32'd0);
    check("ar_stall", 32'(stall_id), 32'd0);
    check("ar_ex_valid", 32'(ex_valid), 32'd0);
    check("ar_ex_ctrl", 32'(ex_ctrl), 32'd0);
    check("ar_ex_rd", 32'(ex_rd), 32'd0);
    check("ar_mem_valid", 32'(mem_valid), 32'd0);
    check("ar_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
